// File: rtl/z86_hazard_scoreboard_if.sv
// z86_hazard_scoreboard_if
// Decode/retire handshake bundle for the hazard scoreboard.
//   master : DECODE/WB side   -- drives flush, issue_*, retire_*; sees status
//   slave  : the scoreboard   -- returns issue_ready, busy, underflow_err, stall_cnt
interface z86_hazard_scoreboard_if #(
  parameter int NUM_RES = 15
);
  logic               flush;
  logic               issue_valid;
  logic [NUM_RES-1:0] issue_rd_mask;
  logic [NUM_RES-1:0] issue_wr_mask;
  logic               issue_ready;
  logic               retire_valid;
  logic [NUM_RES-1:0] retire_mask;
  logic [NUM_RES-1:0] busy;
  logic               underflow_err;
  logic [15:0]        stall_cnt;

  modport master (
    output flush, issue_valid, issue_rd_mask, issue_wr_mask, retire_valid, retire_mask,
    input  issue_ready, busy, underflow_err, stall_cnt
  );

  modport slave (
    input  flush, issue_valid, issue_rd_mask, issue_wr_mask, retire_valid, retire_mask,
    output issue_ready, busy, underflow_err, stall_cnt
  );
endinterface

// File: rtl/z86_hazard_scoreboard.sv
// z86_hazard_scoreboard
// Per-resource in-flight writer counters that replace the single-bit
// reg_mask_t scoreboard. DECODE sees a combinational issue_ready; writers are
// retired by WB/EX; flush clears all counters.
//
// Ports:
//   clk, reset_n   core clock, async active-low reset
//   sb (slave)     flush, issue_valid/rd_mask/wr_mask -> issue_ready,
//                  retire_valid/mask, busy (registered cnt!=0),
//                  underflow_err (sticky), stall_cnt (saturating)
//
// Build option: define Z86_SB_BYPASS_EN to let a same-cycle retire of the
// last outstanding writer release a waiting reader (shorter RAW stall, adds a
// retire->issue_ready combinational path).

// One resource's writer counter.
module z86_sb_res_cnt #(
  parameter int MAX_INFLIGHT = 3,
  parameter int CNT_W        = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic flush,
  input  logic inc,       // issue fired with this resource in wr_mask
  input  logic ret,       // retire_valid & retire_mask[r]
  output logic busy,      // registered cnt != 0
  output logic busy_eff,  // busy as seen by the RAW check
  output logic sat,       // cnt at MAX_INFLIGHT
  output logic empty      // cnt == 0 (retire here is an underflow)
);
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             dec;

  assign empty = (cnt == '0);
  assign sat   = (cnt == CNT_W'(MAX_INFLIGHT));
  assign dec   = ret & ~empty;   // retire on an empty counter is dropped

  always_comb begin
    cnt_nxt = cnt + CNT_W'(inc) - CNT_W'(dec);
    if (flush) cnt_nxt = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= '0;
      busy <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      busy <= (cnt_nxt != '0);
    end
  end

`ifdef Z86_SB_BYPASS_EN
  // Last writer retiring this cycle: reader may go now.
  assign busy_eff = busy & ~(ret & (cnt == CNT_W'(1)));
`else
  assign busy_eff = busy;
`endif
endmodule

module z86_hazard_scoreboard #(
  parameter  int NUM_RES      = 15,
  parameter  int MAX_INFLIGHT = 3,
  localparam int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
  input logic                  clk,
  input logic                  reset_n,
  z86_hazard_scoreboard_if.slave sb
);
  logic [NUM_RES-1:0] busy_v, busy_eff_v, sat_v, empty_v, inc_v, ret_v;
  logic               raw, sat_hit, ready, fire, stall, underflow_hit;

  // WAW is not a hazard: the counters absorb multiple outstanding writers.
  assign raw     = |(sb.issue_rd_mask & busy_eff_v);
  assign sat_hit = |(sb.issue_wr_mask & sat_v);
  assign ready   = ~raw & ~sat_hit;
  assign fire    = sb.issue_valid & ready & ~sb.flush;
  assign stall   = sb.issue_valid & ~ready & ~sb.flush;

  assign inc_v = {NUM_RES{fire}} & sb.issue_wr_mask;
  assign ret_v = {NUM_RES{sb.retire_valid}} & sb.retire_mask;
  assign underflow_hit = |(ret_v & empty_v);

  for (genvar g = 0; g < NUM_RES; g++) begin : g_res
    z86_sb_res_cnt #(
      .MAX_INFLIGHT (MAX_INFLIGHT),
      .CNT_W        (CNT_W)
    ) u_res (
      .clk      (clk),
      .reset_n  (reset_n),
      .flush    (sb.flush),
      .inc      (inc_v[g]),
      .ret      (ret_v[g]),
      .busy     (busy_v[g]),
      .busy_eff (busy_eff_v[g]),
      .sat      (sat_v[g]),
      .empty    (empty_v[g])
    );
  end

  // Status registers survive flush; only reset clears them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sb.underflow_err <= 1'b0;
      sb.stall_cnt     <= '0;
    end else begin
      if (underflow_hit) sb.underflow_err <= 1'b1;
      if (stall && sb.stall_cnt != 16'hFFFF) sb.stall_cnt <= sb.stall_cnt + 16'd1;
    end
  end

  assign sb.issue_ready = ready;
  assign sb.busy        = busy_v;
endmodule

// File: tb/tb_z86_hazard_scoreboard.sv
module tb_z86_hazard_scoreboard;
  localparam int NR  = 15;
  localparam int MAX = 3;
  localparam logic [NR-1:0] AX = 15'h1 << 14, CX = 15'h1 << 13, DX = 15'h1 << 12,
                            BX = 15'h1 << 11, SI = 15'h1 << 8,  DI = 15'h1 << 7,
                            MEM = 15'h1 << 6;

  logic clk = 1'b0, reset_n = 1'b0;
  int   checks = 0, failures = 0;
  logic last_ready;

  // reference state: outstanding writers per resource, sticky error, stall count
  int mcnt [NR];
  bit merr;
  int mstall;

  z86_hazard_scoreboard_if #(.NUM_RES(NR)) sb_if ();
  z86_hazard_scoreboard #(.NUM_RES(NR), .MAX_INFLIGHT(MAX)) dut (
    .clk (clk), .reset_n (reset_n), .sb (sb_if.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [NR-1:0] model_busy();
    logic [NR-1:0] b = '0;
    for (int r = 0; r < NR; r++) b[r] = (mcnt[r] != 0);
    return b;
  endfunction

  function automatic logic model_ready(logic [NR-1:0] rd, logic [NR-1:0] wr,
                                       bit rv, logic [NR-1:0] rm);
    for (int r = 0; r < NR; r++) begin
      bit pending = (mcnt[r] != 0);
`ifdef Z86_SB_BYPASS_EN
      if (rv && rm[r] && mcnt[r] == 1) pending = 0;
`endif
      if (rd[r] && pending) return 1'b0;
      if (wr[r] && mcnt[r] == MAX) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_update(bit fl, bit iv, logic [NR-1:0] rd, logic [NR-1:0] wr,
                              bit rv, logic [NR-1:0] rm);
    logic rdy  = model_ready(rd, wr, rv, rm);
    bit   fire = iv && rdy && !fl;
    if (iv && !rdy && !fl && mstall < 65535) mstall++;
    for (int r = 0; r < NR; r++) begin
      if (rv && rm[r] && mcnt[r] == 0) merr = 1;
      if (fl) mcnt[r] = 0;
      else begin
        if (fire && wr[r]) mcnt[r]++;
        if (rv && rm[r] && mcnt[r] > 0 && !(fire && wr[r] && mcnt[r] == 1 && 0)) ;
      end
    end
    // retire is counted against the pre-issue count; apply it separately
    if (!fl)
      for (int r = 0; r < NR; r++) begin
        int pre = mcnt[r] - ((fire && wr[r]) ? 1 : 0);
        if (rv && rm[r] && pre > 0) mcnt[r]--;
      end
  endtask

  task automatic model_reset();
    for (int r = 0; r < NR; r++) mcnt[r] = 0;
    merr = 0;
    mstall = 0;
  endtask

  task automatic check_regs();
    chk("busy", sb_if.busy, model_busy());
    chk("underflow_err", sb_if.underflow_err, merr);
    chk("stall_cnt", sb_if.stall_cnt, mstall);
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic step(bit fl, bit iv, logic [NR-1:0] rd, logic [NR-1:0] wr,
                      bit rv, logic [NR-1:0] rm);
    check_regs();
    sb_if.flush = fl; sb_if.issue_valid = iv; sb_if.issue_rd_mask = rd;
    sb_if.issue_wr_mask = wr; sb_if.retire_valid = rv; sb_if.retire_mask = rm;
    #1;
    last_ready = sb_if.issue_ready;
    chk("issue_ready", last_ready, model_ready(rd, wr, rv, rm));
    @(posedge clk);
    model_update(fl, iv, rd, wr, rv, rm);
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 0, '0, '0, 0, '0);
  endtask

  initial begin
    logic [NR-1:0] rd, wr, rm;
    model_reset();
    sb_if.flush = 0; sb_if.issue_valid = 0; sb_if.issue_rd_mask = '0;
    sb_if.issue_wr_mask = '0; sb_if.retire_valid = 0; sb_if.retire_mask = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // reset state: everything clear, ready for any masks
    check_regs();
    sb_if.issue_rd_mask = '1; sb_if.issue_wr_mask = '1;
    #1 chk("reset_ready", sb_if.issue_ready, 1'b1);
    sb_if.issue_rd_mask = '0; sb_if.issue_wr_mask = '0;

    // RAW on AX
    step(0, 1, '0, AX, 0, '0);
    step(0, 1, AX, '0, 0, '0);
    chk("ax_raw_stall", last_ready, 1'b0);
    step(0, 1, AX, '0, 1, AX);
`ifdef Z86_SB_BYPASS_EN
    chk("ax_ready_retire_cycle", last_ready, 1'b1);
`else
    chk("ax_ready_retire_cycle", last_ready, 1'b0);
    step(0, 1, AX, '0, 0, '0);
    chk("ax_ready_after_retire", last_ready, 1'b1);
`endif
    idle();

    // BX saturation at MAX_INFLIGHT
    repeat (3) step(0, 1, '0, BX, 0, '0);
    step(0, 1, '0, BX, 0, '0);
    chk("bx_sat_stall", last_ready, 1'b0);
    step(0, 1, '0, BX, 1, BX);
    chk("bx_sat_during_retire", last_ready, 1'b0);
    step(0, 1, '0, BX, 0, '0);
    chk("bx_fourth_issues", last_ready, 1'b1);
    step(0, 1, '0, BX, 0, '0);
    chk("bx_back_at_max", last_ready, 1'b0);
    step(1, 0, '0, '0, 0, '0);

    // CX simultaneous issue+retire holds cnt at 1
    step(0, 1, '0, CX, 0, '0);
    step(0, 1, '0, CX, 1, CX);
    chk("cx_busy_held", sb_if.busy[13], 1'b1);
    step(0, 0, '0, '0, 1, CX);
    chk("cx_cleared_one_retire", sb_if.busy[13], 1'b0);

    // flush with concurrent issue drops the issue
    step(0, 1, '0, SI, 0, '0);
    step(0, 1, '0, SI | MEM, 0, '0);
    step(1, 1, '0, DI, 0, '0);
    chk("flush_busy", sb_if.busy, 15'h0);
    step(0, 1, DI, '0, 0, '0);
    chk("di_not_recorded", last_ready, 1'b1);

    // DX underflow is sticky across flush
    step(0, 0, '0, '0, 1, DX);
    chk("dx_underflow", sb_if.underflow_err, 1'b1);
    chk("dx_no_busy", sb_if.busy[12], 1'b0);
    step(1, 0, '0, '0, 0, '0);
    chk("underflow_after_flush", sb_if.underflow_err, 1'b1);

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      rd = ($urandom % 3 == 0) ? '0 : NR'(1) << ($urandom % NR);
      if ($urandom % 4 == 0) rd |= NR'(1) << ($urandom % NR);
      wr = ($urandom % 4 == 0) ? '0 : NR'(1) << ($urandom % NR);
      if ($urandom % 5 == 0) wr |= NR'(1) << ($urandom % NR);
      rm = ($urandom % 8 == 0) ? NR'($urandom) : (model_busy() & NR'($urandom));
      step($urandom % 50 == 0, $urandom % 4 != 0, rd, wr, $urandom % 2 == 1, rm);
    end

    // long RAW stall saturates stall_cnt
    step(1, 0, '0, '0, 0, '0);
    step(0, 1, '0, AX, 0, '0);
    check_regs();
    sb_if.issue_valid = 1; sb_if.issue_rd_mask = AX; sb_if.issue_wr_mask = '0;
    #1 chk("long_stall_ready", sb_if.issue_ready, 1'b0);
    repeat (70000) @(posedge clk);
    mstall = (mstall + 70000 > 65535) ? 65535 : mstall + 70000;
    @(negedge clk);
    chk("stall_sat", sb_if.stall_cnt, 16'hFFFF);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("stall_sat_hold", sb_if.stall_cnt, 16'hFFFF);
    check_regs();

    // async reset mid-operation with a retire pending
    sb_if.issue_valid = 0; sb_if.retire_valid = 1; sb_if.retire_mask = AX;
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    chk("rst_busy", sb_if.busy, 15'h0);
    chk("rst_stall", sb_if.stall_cnt, 16'h0);
    chk("rst_underflow", sb_if.underflow_err, 1'b0);
    @(negedge clk);
    sb_if.retire_valid = 0; sb_if.retire_mask = '0;
    reset_n = 1'b1;
    idle();
    check_regs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/z86_hazard_scoreboard.md
# z86_hazard_scoreboard

Parametrised register/resource hazard scoreboard for the z86 decode→execute pipeline. It generalises the single-bit `reg_mask_t` scoreboard into per-resource in-flight writer counters, so several outstanding writers to one resource are tracked exactly. DECODE presents each instruction's read/write resource masks and receives a stall decision. WB/EX retire writes, and a branch/interrupt flush clears all state.

## Interface
Parameters:
- `NUM_RES`, 15, number of tracked resources. Default bit order is gpr[7:0], mem, seg[3:0] (ES/CS/SS/DS), stackop, io, matching `reg_mask_t` packing (bit 14 = gpr[7] … bit 0 = io).
- `MAX_INFLIGHT`, 3, maximum outstanding writers per resource (≥1).
- `CNT_W`, `$clog2(MAX_INFLIGHT+1)`, per-resource counter width (derived, not overridden).

Ports:
- `clk`  in  1  core clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous clear of all pending state.
- `issue_valid`  in  1  DECODE has an instruction to issue.
- `issue_rd_mask`  in  NUM_RES  resources read by the instruction.
- `issue_wr_mask`  in  NUM_RES  resources written by the instruction.
- `issue_ready`  out  1  no hazard; the instruction may issue this cycle.
- `retire_valid`  in  1  a write completes this cycle.
- `retire_mask`  in  NUM_RES  resources whose write completes.
- `busy`  out  NUM_RES  registered: bit set when counter ≠ 0.
- `underflow_err`  out  1  sticky: retire seen on a zero counter.
- `stall_cnt`  out  16  saturating count of stalled cycles.

## Operation
- Each resource r has counter `cnt[r]` (CNT_W bits), holding the number of issued-but-unretired writers.
- Effective busy: `busy_eff[r] = busy[r]`. With bypass enabled (see Configuration), the bit is forced to 0 when `retire_valid & retire_mask[r] & cnt[r]==1`.
- Hazard terms:
  - RAW: `|(issue_rd_mask & busy_eff)`.
  - Saturation: `|(issue_wr_mask & (cnt==MAX_INFLIGHT))`.
  - WAW is permitted, because counters track it.
- `issue_ready = ~RAW & ~saturation`. It is combinational and independent of `issue_valid`.
- Fire = `issue_valid & issue_ready & ~flush`.
- Counter update per r, in priority order:
  1. flush: cnt←0.
  2. Otherwise `cnt + (fire & wr_mask[r]) − (retire_valid & retire_mask[r] & cnt≠0)`.
- Simultaneous issue and retire on the same r leaves cnt unchanged.
- A retire on a resource whose cnt==0 is ignored, and `underflow_err` is set to 1. Only reset clears `underflow_err`; flush does not.
- `stall_cnt` increments when `issue_valid & ~issue_ready & ~flush`, saturates at 16'hFFFF, and is cleared only by reset.
- `busy` is the registered form `cnt≠0`, updated in the same edge as cnt.

## Timing
- Reset (async assert, sync release): all cnt=0, `busy`=0, `underflow_err`=0, `stall_cnt`=0. `issue_ready` is 1 for any masks.
- Issue at edge N: `busy` is visible after N. A dependent reader presented in cycle N+1 stalls.
- Retire in cycle M, without bypass: `busy` clears after edge M, so the dependent issues in M+1. This gives a 2-cycle RAW wait from producer EX.
- Retire in cycle M, with bypass: the dependent issues in cycle M. This gives a 1-cycle RAW wait.
- Flush in cycle F: state is clear after edge F, and any issue presented in F is dropped. `issue_ready` in F still reflects the pre-flush state.
- `reset_n` asserted mid-operation clears everything immediately, with no pending retire accepted.

## Configuration
- `Z86_SB_BYPASS_EN`:
  - Defined: same-cycle retire of the last writer clears `busy_eff`, so the reader issues in the retire cycle. This trades Fmax for a shorter RAW stall.
  - Undefined: `busy_eff = busy`, with no combinational path from `retire_*` to `issue_ready`.

## Test plan
- Reset, then issue wr=AX (bit 14); next cycle present rd=AX → `issue_ready`=0 and `stall_cnt` increments. Retire AX in cycle M → ready=1 in M (bypass) or M+1 (no bypass).
- Three back-to-back writes to BX with MAX_INFLIGHT=3, then a fourth write → fourth stalls. One retire → fourth issues next cycle, and cnt[BX] returns to 3.
- Issue wr=CX and retire CX in the same cycle with cnt[CX]=1 → cnt stays 1 and `busy[CX]`=1.
- Retire DX when cnt[DX]=0 → cnt stays 0, `underflow_err`=1, and it persists across flush.
- With cnt[SI]=2 and cnt[mem]=1, assert flush together with issue_valid wr=DI → all `busy`=0 next cycle and DI not recorded.
- Hold a RAW stall for 70000 cycles → `stall_cnt`=16'hFFFF and holds there.
